// File: rtl/sensor_transform_if.sv
// Sensor/board bus for sensor_transform: chain-order input, row-major outputs.
interface sensor_transform_if #(
   parameter int W = 32
);
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic [W-1:0] changed;
   logic         change_pulse;

   modport master (output data_in, input data_out, changed, change_pulse);
   modport slave  (input data_in, output data_out, changed, change_pulse);
endinterface

// File: rtl/sensor_transform.sv
// Serpentine sensor chain to row-major square remap with change detection.
// Optional per-bit input debounce is enabled by defining TRANSFORM_DEBOUNCE_EN.
`ifdef TRANSFORM_DEBOUNCE_EN
module sensor_transform_debounce #(
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw,
   output logic stable
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt;

   // stable only follows raw after DEBOUNCE_CYCLES consecutive differing edges
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (raw == stable) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         stable <= raw;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule
`endif

module sensor_transform #(
   parameter int ROWS            = 8,
   parameter int COLS            = 4,
   parameter int SERPENTINE      = 1,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input logic              clk,
   input logic              resetn,
   sensor_transform_if.slave bus
);
   localparam int W = ROWS * COLS;

   logic [W-1:0] src;
   logic [W-1:0] mapped;
   logic [W-1:0] data_q;
   logic [W-1:0] changed_q;
   logic         pulse_q;

`ifdef TRANSFORM_DEBOUNCE_EN
   for (genvar i = 0; i < W; i++) begin : g_deb
      sensor_transform_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (clk),
         .resetn (resetn),
         .raw    (bus.data_in[i]),
         .stable (src[i])
      );
   end
`else
   assign src = bus.data_in;
`endif

   // Odd rows run backwards along the chain when SERPENTINE is set
   for (genvar s = 0; s < W; s++) begin : g_map
      localparam int R   = s / COLS;
      localparam int C   = s % COLS;
      localparam int SRC = (SERPENTINE != 0 && (R % 2) == 1) ? (R * COLS + (COLS - 1 - C)) : s;
      assign mapped[s] = src[SRC];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_q    <= '0;
         changed_q <= '0;
         pulse_q   <= 1'b0;
      end else begin
         data_q    <= mapped;
         changed_q <= mapped ^ data_q;
         pulse_q   <= |(mapped ^ data_q);
      end
   end

   assign bus.data_out     = data_q;
   assign bus.changed      = changed_q;
   assign bus.change_pulse = pulse_q;
endmodule

// File: tb/tb_sensor_transform.sv
// Scoreboard bench for sensor_transform: serpentine and straight instances side by side.
module tb_sensor_transform;
   localparam int DEB = 4;
`ifdef TRANSFORM_DEBOUNCE_EN
   localparam int LAT = DEB + 1;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      string       tag;
      logic [31:0] dout_s;
      logic [31:0] chg_s;
      logic [31:0] dout_p;
      logic [31:0] chg_p;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [31:0] prev_s = '0;
   logic [31:0] prev_p = '0;
   logic [31:0] seen = '0;

   sensor_transform_if #(.W(32)) bus_s ();
   sensor_transform_if #(.W(32)) bus_p ();

   sensor_transform #(.ROWS(8), .COLS(4), .SERPENTINE(1), .DEBOUNCE_CYCLES(DEB)) u_serp (
      .clk(clk), .resetn(resetn), .bus(bus_s));
   sensor_transform #(.ROWS(8), .COLS(4), .SERPENTINE(0), .DEBOUNCE_CYCLES(DEB)) u_flat (
      .clk(clk), .resetn(resetn), .bus(bus_p));

   always #5 clk = ~clk;

   // chain position -> square: odd rows are laid backwards in the chain
   function automatic logic [31:0] model_serp(input logic [31:0] v);
      logic [31:0] o = '0;
      for (int i = 0; i < 32; i++) begin
         int row = i / 4;
         int pos = i % 4;
         int sq  = (row % 2 == 1) ? row * 4 + (3 - pos) : i;
         o[sq] = v[i];
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, "_dout_s"}, bus_s.data_out, e.dout_s);
      chk({e.tag, "_chg_s"}, bus_s.changed, e.chg_s);
      chk({e.tag, "_pls_s"}, {31'd0, bus_s.change_pulse}, {31'd0, |e.chg_s});
      chk({e.tag, "_dout_p"}, bus_p.data_out, e.dout_p);
      chk({e.tag, "_chg_p"}, bus_p.changed, e.chg_p);
      chk({e.tag, "_pls_p"}, {31'd0, bus_p.change_pulse}, {31'd0, |e.chg_p});
   endtask

   task automatic step(input logic [31:0] v, input string tag);
      exp_t e;
      bus_s.data_in = v;
      bus_p.data_in = v;
      e.tag    = tag;
      e.dout_s = model_serp(v);
      e.chg_s  = e.dout_s ^ prev_s;
      e.dout_p = v;
      e.chg_p  = v ^ prev_p;
      prev_s   = e.dout_s;
      prev_p   = e.dout_p;
      sb.push_back(e);
      repeat (LAT) @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic do_reset(input string tag);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_dout"}, bus_s.data_out | bus_p.data_out, 32'h0);
      chk({tag, "_chg"}, bus_s.changed | bus_p.changed, 32'h0);
      chk({tag, "_pls"}, {30'd0, bus_s.change_pulse, bus_p.change_pulse}, 32'h0);
      prev_s = '0;
      prev_p = '0;
      resetn = 1'b1;
   endtask

   initial begin
      bus_s.data_in = '0;
      bus_p.data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset("reset");

      step(32'h0000_0001, "first");
      step(32'h0000_0001, "hold");
      step(32'h0000_0010, "row1_pos0");
      step(32'h0000_0080, "row1_pos3");
      step(32'h0000_00F0, "row1_full");
      step(32'hF000_0000, "row7_full");
      step(32'h1000_0000, "row7_pos0");
      step(32'hFFFF_FFFF, "all_ones");
      step(32'hFFFF_FFFE, "drop_bit0");

      do_reset("mid_reset");
      step(32'hFFFF_FFFE, "post_reset");

      // walking one: every chain bit must land on a single, distinct square
      for (int i = 0; i < 32; i++) begin
         step(32'h1 << i, $sformatf("walk%0d", i));
         chk($sformatf("walk%0d_onehot_s", i), {31'd0, $onehot(bus_s.data_out)}, 32'h1);
         chk($sformatf("walk%0d_fresh_s", i), seen & bus_s.data_out, 32'h0);
         seen = seen | bus_s.data_out;
      end
      chk("walk_cover_s", seen, 32'hFFFF_FFFF);

`ifdef TRANSFORM_DEBOUNCE_EN
      do_reset("deb_reset");
      bus_s.data_in = 32'h1;
      bus_p.data_in = 32'h1;
      repeat (3) @(posedge clk);
      bus_s.data_in = 32'h0;
      bus_p.data_in = 32'h0;
      repeat (DEB + 2) @(posedge clk);
      #1;
      chk("deb_glitch_dout", bus_s.data_out | bus_p.data_out, 32'h0);
      chk("deb_glitch_pls", {30'd0, bus_s.change_pulse, bus_p.change_pulse}, 32'h0);
      bus_s.data_in = 32'h1;
      bus_p.data_in = 32'h1;
      repeat (DEB) @(posedge clk);
      #1;
      chk("deb_edge4_dout", bus_s.data_out, 32'h0);
      @(posedge clk);
      #1;
      chk("deb_edge5_dout", bus_s.data_out, 32'h1);
      chk("deb_edge5_pls", {31'd0, bus_s.change_pulse}, 32'h1);
      @(posedge clk);
      #1;
      chk("deb_edge6_pls", {31'd0, bus_s.change_pulse}, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
